// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported memory.
// Each access runs IDLE -> ISSUE -> DONE; DONE may hand straight over to the other port.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_address,
  output logic        inst_ready,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_frame_mask,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } state_e;

  localparam logic        OWN_INST = 1'b0;
  localparam logic        OWN_DATA = 1'b1;
  localparam int unsigned CW       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT  = CW'(STARVE_LIMIT);

  state_e        r_state;
  logic          r_owner;
  logic          r_we;
  logic [CW-1:0] r_starve;

  logic w_grant_inst;
  logic w_grant_data;

  // DONE only considers the port that did not just finish, which gives strict alternation.
  always_comb begin
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (data_req && !(inst_req && (r_starve == LIMIT))) begin
          w_grant_data = 1'b1;
        end else if (inst_req) begin
          w_grant_inst = 1'b1;
        end
      end
      StDone: begin
        if (r_owner == OWN_DATA) begin
          w_grant_inst = inst_req;
        end else begin
          w_grant_data = data_req;
        end
      end
      default: begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_owner        <= OWN_INST;
      r_we           <= 1'b0;
      r_starve       <= '0;
      inst_ready     <= 1'b0;
      inst_rdata     <= 32'd0;
      data_ready     <= 1'b0;
      data_rdata     <= 32'd0;
      mem_enable     <= 1'b0;
      mem_state      <= 1'b0;
      mem_address    <= 32'd0;
      mem_frame_mask <= 4'd0;
      mem_wdata      <= 32'd0;
      arb_busy       <= 1'b0;
    end else begin
      if (!inst_req || w_grant_inst) begin
        r_starve <= '0;
      end else if (w_grant_data && (r_starve != LIMIT)) begin
        r_starve <= r_starve + 1'b1;
      end

      unique case (r_state)
        StIdle, StDone: begin
          inst_ready <= 1'b0;
          inst_rdata <= 32'd0;
          data_ready <= 1'b0;
          data_rdata <= 32'd0;
          if (w_grant_data) begin
            r_state        <= StIssue;
            r_owner        <= OWN_DATA;
            r_we           <= data_we;
            mem_enable     <= 1'b1;
            mem_state      <= data_we;
            mem_address    <= data_address;
            mem_frame_mask <= data_frame_mask;
            mem_wdata      <= data_wdata;
            arb_busy       <= 1'b1;
          end else if (w_grant_inst) begin
            r_state        <= StIssue;
            r_owner        <= OWN_INST;
            r_we           <= 1'b0;
            mem_enable     <= 1'b1;
            mem_state      <= 1'b0;
            mem_address    <= inst_address;
            mem_frame_mask <= 4'b1111;
            mem_wdata      <= 32'd0;
            arb_busy       <= 1'b1;
          end else begin
            r_state  <= StIdle;
            arb_busy <= 1'b0;
          end
        end
        StIssue: begin
          r_state        <= StDone;
          arb_busy       <= 1'b1;
          mem_enable     <= 1'b0;
          mem_state      <= 1'b0;
          mem_address    <= 32'd0;
          mem_frame_mask <= 4'd0;
          mem_wdata      <= 32'd0;
          if (r_owner == OWN_INST) begin
            inst_ready <= 1'b1;
            inst_rdata <= mem_rdata;
          end else begin
            data_ready <= 1'b1;
            data_rdata <= r_we ? 32'd0 : mem_rdata;
          end
        end
        default: begin
          r_state  <= StIdle;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: slot-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_memory_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_address = 32'd0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_address = 32'd0;
  logic [3:0]  data_frame_mask = 4'd0;
  logic [31:0] data_wdata = 32'd0;
  logic        inst_ready, data_ready, mem_enable, mem_state, arb_busy;
  logic [31:0] inst_rdata, data_rdata, mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_frame_mask;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : ((a ^ 32'hA5A5_0000) + 32'd3);
  endfunction

  // Garbage outside ISSUE so a mistimed capture shows up.
  assign mem_rdata = mem_enable ? memfn(mem_address) : 32'hBAD0_BAD0;

  memory_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .reset(reset),
    .inst_req(inst_req), .inst_address(inst_address),
    .inst_ready(inst_ready), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_address(data_address),
    .data_frame_mask(data_frame_mask), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_enable(mem_enable), .mem_state(mem_state), .mem_address(mem_address),
    .mem_frame_mask(mem_frame_mask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Model: one memory slot (ISSUE) feeding one completion slot (DONE).
  logic        m_iss_v = 0, m_iss_port = 0, m_iss_we = 0;  // port 1 = data
  logic [31:0] m_iss_addr = 0, m_iss_wdata = 0;
  logic [3:0]  m_iss_mask = 0;
  logic        m_done_v = 0, m_done_port = 0;
  logic [31:0] m_done_rdata = 0;
  int          m_starve = 0;

  initial begin : model
    logic gi, gd;
    forever begin
      @(posedge CLK or negedge reset);
      if (!reset) begin
        m_iss_v = 0; m_iss_port = 0; m_iss_we = 0; m_iss_addr = 0; m_iss_wdata = 0;
        m_iss_mask = 0; m_done_v = 0; m_done_port = 0; m_done_rdata = 0; m_starve = 0;
      end else begin
        gi = 0;
        gd = 0;
        if (m_done_v) begin
          if (m_done_port) gi = inst_req;
          else gd = data_req;
        end else if (!m_iss_v) begin
          if (data_req && !(inst_req && m_starve == LIM)) gd = 1;
          else if (inst_req) gi = 1;
        end
        m_done_v     = m_iss_v;
        m_done_port  = m_iss_port;
        m_done_rdata = (!m_iss_v || (m_iss_port && m_iss_we)) ? 32'd0 : memfn(m_iss_addr);
        m_iss_v = gi | gd;
        if (gd) begin
          m_iss_port = 1; m_iss_we = data_we; m_iss_addr = data_address;
          m_iss_mask = data_frame_mask; m_iss_wdata = data_wdata;
        end else if (gi) begin
          m_iss_port = 0; m_iss_we = 0; m_iss_addr = inst_address;
          m_iss_mask = 4'hF; m_iss_wdata = 0;
        end else begin
          m_iss_port = 0; m_iss_we = 0; m_iss_addr = 0; m_iss_mask = 0; m_iss_wdata = 0;
        end
        if (!inst_req || gi) m_starve = 0;
        else if (gd && m_starve < LIM) m_starve++;
      end
    end
  end

  initial forever begin : compare
    @(negedge CLK);
    check("mem_enable", {31'd0, mem_enable}, {31'd0, m_iss_v});
    check("mem_state", {31'd0, mem_state}, {31'd0, m_iss_we});
    check("mem_address", mem_address, m_iss_addr);
    check("mem_frame_mask", {28'd0, mem_frame_mask}, {28'd0, m_iss_mask});
    check("mem_wdata", mem_wdata, m_iss_wdata);
    check("inst_ready", {31'd0, inst_ready}, {31'd0, m_done_v && !m_done_port});
    check("inst_rdata", inst_rdata, (m_done_v && !m_done_port) ? m_done_rdata : 32'd0);
    check("data_ready", {31'd0, data_ready}, {31'd0, m_done_v && m_done_port});
    check("data_rdata", data_rdata, (m_done_v && m_done_port) ? m_done_rdata : 32'd0);
    check("arb_busy", {31'd0, arb_busy}, {31'd0, m_iss_v || m_done_v});
  end

  // Requester agents: hold each request until its ready pulse, life>0 drops it early.
  typedef struct { logic [31:0] addr; int life; } itx_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata; int life; } dtx_t;
  itx_t inst_q[$];
  dtx_t data_q[$];
  byte  ord[$];
  bit   inst_act = 0, data_act = 0, scramble = 0;
  int   inst_life = 0, data_life = 0, inst_cnt = 0, data_cnt = 0, inst_assert_cyc = 0;

  initial begin : driver
    itx_t it;
    dtx_t dt;
    bit i_new, d_new;
    forever begin
      @(negedge CLK);
      i_new = 0;
      d_new = 0;
      if (inst_ready === 1'b1) begin
        ord.push_back("I"); inst_cnt++; inst_req = 0; inst_act = 0;
      end
      if (data_ready === 1'b1) begin
        ord.push_back("D"); data_cnt++; data_req = 0; data_act = 0;
      end
      if (inst_act && inst_life > 0) begin
        inst_life--;
        if (inst_life == 0) begin inst_req = 0; inst_act = 0; end
      end
      if (data_act && data_life > 0) begin
        data_life--;
        if (data_life == 0) begin data_req = 0; data_act = 0; end
      end
      if (!inst_act && inst_q.size() != 0) begin
        it = inst_q.pop_front();
        inst_address = it.addr; inst_life = it.life; inst_req = 1; inst_act = 1;
        inst_assert_cyc = cyc; i_new = 1;
      end
      if (!data_act && data_q.size() != 0) begin
        dt = data_q.pop_front();
        data_we = dt.we; data_address = dt.addr; data_frame_mask = dt.mask;
        data_wdata = dt.wdata; data_life = dt.life; data_req = 1; data_act = 1; d_new = 1;
      end
      if (scramble) begin
        if (inst_act && !i_new) inst_address = $urandom;
        if (data_act && !d_new) begin
          data_address = $urandom; data_wdata = $urandom;
          data_frame_mask = 4'($urandom); data_we = 1'($urandom);
        end
      end
    end
  end

  task automatic sync();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_for(input string name, input int sel, output int at);
    int  n;
    logic s;
    n = 0;
    do begin
      @(negedge CLK);
      s = (sel == 0) ? mem_enable : (sel == 1) ? inst_ready : data_ready;
      n++;
    end while (s !== 1'b1 && n < 50);
    check({name, "_seen"}, {31'd0, s === 1'b1}, 32'd1);
    at = cyc;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((inst_q.size() != 0 || data_q.size() != 0 || inst_act || data_act ||
            arb_busy !== 1'b0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_quiet"}, {31'd0, n < 300}, 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {27'd0, mem_enable, mem_state, inst_ready, data_ready, arb_busy}, 0);
    check({name, "_addr_mask"}, mem_address | {28'd0, mem_frame_mask}, 0);
    check({name, "_wdata"}, mem_wdata, 0);
    check({name, "_rdata"}, inst_rdata | data_rdata, 0);
  endtask

  initial begin : main
    int    c1, c2, idx, cnt0;
    string exp_s;
    #1 reset = 0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge CLK);
    #2 reset = 1;

    // Instruction read latency and data.
    inst_q.push_back('{32'h10, 0});
    wait_for("i_issue", 0, c1);
    check("i_latency_issue", c1, inst_assert_cyc + 1);
    check("i_mem_addr", mem_address, 32'h10);
    check("i_mem_mask", {28'd0, mem_frame_mask}, 32'hF);
    wait_for("i_ready", 1, c2);
    check("i_latency_ready", c2, c1 + 1);
    check("i_rdata", inst_rdata, 32'hDEAD_BEEF);
    wait_quiet("inst_read");

    // Data write then data read.
    sync();
    data_q.push_back('{1'b1, 32'h20, 4'b0011, 32'h1234_5678, 0});
    wait_for("dw_issue", 0, c1);
    check("dw_state", {31'd0, mem_state}, 1);
    check("dw_addr", mem_address, 32'h20);
    check("dw_mask", {28'd0, mem_frame_mask}, 32'h3);
    check("dw_wdata", mem_wdata, 32'h1234_5678);
    wait_for("dw_ready", 2, c2);
    check("dw_rdata", data_rdata, 0);
    wait_quiet("data_write");
    sync();
    data_q.push_back('{1'b0, 32'h44, 4'hF, 32'h0, 0});
    wait_for("dr_ready", 2, c2);
    check("dr_rdata", data_rdata, 32'hA5A5_0047);
    wait_quiet("data_read");

    // Simultaneous first requests: data first, instruction right after data's DONE.
    sync();
    ord.delete();
    inst_q.push_back('{32'h100, 0});
    data_q.push_back('{1'b0, 32'h200, 4'hF, 32'h0, 0});
    wait_for("sim_d_ready", 2, c1);
    @(negedge CLK);
    check("sim_i_issue", {31'd0, mem_enable}, 1);
    check("sim_i_addr", mem_address, 32'h100);
    wait_quiet("simultaneous");
    check("sim_first", {24'd0, ord[0]}, {24'd0, 8'h44});

    // Both ports held continuously: strict alternation.
    sync();
    ord.delete();
    for (int i = 0; i < 4; i++) begin
      inst_q.push_back('{32'h400 + 32'(i * 4), 0});
      data_q.push_back('{1'(i), 32'h800 + 32'(i * 4), 4'(i + 5), 32'hC0DE_0000 + 32'(i), 0});
    end
    wait_quiet("alternate");
    exp_s = "DIDIDIDI";
    check("alt_count", ord.size(), 8);
    for (int i = 0; i < 8 && i < ord.size(); i++) check("alt_order", {24'd0, ord[i]}, {24'd0, exp_s[i]});

    // Data-only stream with a late instruction request.
    sync();
    ord.delete();
    for (int i = 0; i < 6; i++) data_q.push_back('{1'b0, 32'h900 + 32'(i * 4), 4'hF, 0, 0});
    wait_for("late_d1", 2, c1);
    sync();
    inst_q.push_back('{32'h500, 0});
    wait_quiet("late_inst");
    idx = -1;
    for (int i = 0; i < ord.size(); i++) if (idx < 0 && ord[i] == "I") idx = i;
    check("late_inst_pos", idx, 2);
    check("late_count", ord.size(), 7);

    // Fields change while pending or in flight.
    sync();
    scramble = 1;
    for (int i = 0; i < 3; i++) begin
      inst_q.push_back('{32'hA00 + 32'(i * 4), 0});
      data_q.push_back('{1'b0, 32'hB00 + 32'(i * 4), 4'hF, 0, 0});
    end
    wait_quiet("scramble");
    scramble = 0;

    // Instruction request withdrawn before it can be granted.
    sync();
    cnt0 = inst_cnt;
    data_q.push_back('{1'b1, 32'hC00, 4'hF, 32'h5555_AAAA, 0});
    @(posedge CLK);
    #2 inst_q.push_back('{32'hD00, 1});
    wait_quiet("withdraw");
    check("withdraw_no_inst", inst_cnt, cnt0);

    // Reset in the middle of ISSUE.
    sync();
    cnt0 = inst_cnt;
    inst_q.push_back('{32'h300, 0});
    wait_for("rst_issue", 0, c1);
    #1 reset = 0;
    #1 check_all_zero("rst_mid_issue");
    repeat (2) @(posedge CLK);
    #2 reset = 1;
    wait_for("rst_replay_ready", 1, c2);
    check("rst_replay_rdata", inst_rdata, 32'hA5A5_0303);
    wait_quiet("reset_mid");
    check("rst_one_pulse", inst_cnt, cnt0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
